// File: rtl/sram_bist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST engine.
package sram_bist_pkg;

    // One memory operation: read or write of the all-zeros / all-ones word.
    typedef enum logic [1:0] {OP_R0, OP_W0, OP_R1, OP_W1} march_op_e;

    // Controller FSM states.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;

    // One march element: index, address direction and up to two ops per address.
    typedef struct packed {
        logic [2:0] idx;
        logic       up;
        logic [1:0] nops;
        march_op_e  op0;
        march_op_e  op1;
    } march_elem_t;

    localparam int NUM_ELEM = 6;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    localparam march_elem_t MARCH_TBL [NUM_ELEM] = '{
        '{idx: 3'd0, up: 1'b1, nops: 2'd1, op0: OP_W0, op1: OP_W0},
        '{idx: 3'd1, up: 1'b1, nops: 2'd2, op0: OP_R0, op1: OP_W1},
        '{idx: 3'd2, up: 1'b1, nops: 2'd2, op0: OP_R1, op1: OP_W0},
        '{idx: 3'd3, up: 1'b0, nops: 2'd2, op0: OP_R0, op1: OP_W1},
        '{idx: 3'd4, up: 1'b0, nops: 2'd2, op0: OP_R1, op1: OP_W0},
        '{idx: 3'd5, up: 1'b1, nops: 2'd1, op0: OP_R0, op1: OP_R0}
    };

    function automatic logic elem_up(input logic [2:0] e);
        return MARCH_TBL[e].up;
    endfunction

    function automatic logic elem_dual(input logic [2:0] e);
        return MARCH_TBL[e].nops == 2'd2;
    endfunction

    function automatic march_op_e elem_op(input logic [2:0] e, input logic step);
        return step ? MARCH_TBL[e].op1 : MARCH_TBL[e].op0;
    endfunction

    function automatic logic op_is_rd(input march_op_e op);
        return (op == OP_R0) || (op == OP_R1);
    endfunction

    // Data pattern of an op: 1 means the all-ones word.
    function automatic logic op_pat(input march_op_e op);
        return (op == OP_R1) || (op == OP_W1);
    endfunction

endpackage

// File: rtl/sram_march_bist_ctrl_if.sv
// Control/status and SRAM BIST-port bundle of the March C- engine.
interface sram_march_bist_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64,
    parameter int ERR_W  = 16
);
    logic              start_i;
    logic              busy_o;
    logic              done_o;
    logic              pass_o;
    logic [ADDR_W-1:0] fail_addr_o;
    logic [2:0]        fail_elem_o;
    logic [ERR_W-1:0]  err_cnt_o;
    logic              bist_en_o;
    logic              bist_men_o;
    logic              bist_wen_o;
    logic              bist_ren_o;
    logic [ADDR_W-1:0] bist_addr_o;
    logic [DATA_W-1:0] bist_din_o;
    logic [DATA_W-1:0] bist_bm_o;
    logic [DATA_W-1:0] bist_dout_i;

    // BIST engine side
    modport master (
        input  start_i, bist_dout_i,
        output busy_o, done_o, pass_o, fail_addr_o, fail_elem_o, err_cnt_o,
               bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
               bist_addr_o, bist_din_o, bist_bm_o
    );

    // Test controller / SRAM macro side
    modport slave (
        output start_i, bist_dout_i,
        input  busy_o, done_o, pass_o, fail_addr_o, fail_elem_o, err_cnt_o,
               bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
               bist_addr_o, bist_din_o, bist_bm_o
    );
endinterface

// File: rtl/sram_bist_cmp.sv
// Read-data checker: aligns expected data with the 1-cycle SRAM read latency,
// counts miscompares (saturating) and captures the first failing address/element.
module sram_bist_cmp #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64,
    parameter int ERR_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr,
    input  logic              fin,
    input  logic              rd_vld,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_elem,
    input  logic [DATA_W-1:0] dout,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [ERR_W-1:0]  err_cnt
);

    logic              vld_p0;
    logic [DATA_W-1:0] exp_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [2:0]        elem_p0;
    logic              miscmp;
    logic [ERR_W-1:0]  err_q;
    logic [ERR_W-1:0]  err_d;
    logic              pass_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [2:0]        fail_elem_q;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // Stage p0: read is captured by the macro at this edge; DOUT follows next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) vld_p0 <= 1'b0;
        else       vld_p0 <= rd_vld & ~clr;
    end

    // Stage p0 data companions of vld_p0.
    always_ff @(posedge clk_i) begin
        exp_p0  <= rd_exp;
        addr_p0 <= rd_addr;
        elem_p0 <= rd_elem;
    end

    assign miscmp = vld_p0 && (dout != exp_p0);

    always_comb begin
        err_d = err_q;
        if (clr)         err_d = '0;
        else if (miscmp) err_d = sat_inc(err_q);
    end

    // Stage p1: error count, first-fail capture and pass flag at end of test.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            err_q <= err_d;
            if (clr) begin
                fail_addr_q <= '0;
                fail_elem_q <= '0;
            end else if (miscmp && (err_q == '0)) begin
                fail_addr_q <= addr_p0;
                fail_elem_q <= elem_p0;
            end
            if (clr)      pass_q <= 1'b0;
            else if (fin) pass_q <= (err_d == '0);
        end
    end

    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign err_cnt   = err_q;

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST engine driving the BIST port of a single-port SRAM macro.
// One op per cycle, all bus outputs registered; the final read is checked in DRAIN.
module sram_march_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2048,
    parameter int ERR_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    sram_march_bist_ctrl_if.master  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bist_state_e       state_q, state_d;
    logic [2:0]        elem_q, elem_d, elem_inc;
    logic              step_q, step_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              issue;
    logic              start_ok;
    logic              busy_d;
    march_op_e         op_d;
    logic              rd_d;
    logic              pat_d;

    logic              busy_q, done_q, en_q;
    logic              men_q, wen_q, ren_q;
    logic [ADDR_W-1:0] addr_out_q;
    logic [DATA_W-1:0] din_q, bm_q, exp_q;
    logic [2:0]        elem_out_q;
    logic              fin;
    logic              cmp_pass;
    logic [ADDR_W-1:0] cmp_fail_addr;
    logic [2:0]        cmp_fail_elem;
    logic [ERR_W-1:0]  cmp_err_cnt;

    function automatic logic [ADDR_W-1:0] first_addr(input logic [2:0] e);
        return elem_up(e) ? '0 : LAST_ADDR;
    endfunction

    function automatic logic [ADDR_W-1:0] final_addr(input logic [2:0] e);
        return elem_up(e) ? LAST_ADDR : '0;
    endfunction

    assign elem_inc = elem_q + 3'd1;

    // Next-state and sequencer: picks the op to present in the next cycle.
    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        step_d   = step_q;
        addr_d   = addr_q;
        issue    = 1'b0;
        start_ok = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    start_ok = 1'b1;
                    state_d  = RUN;
                    elem_d   = '0;
                    step_d   = 1'b0;
                    addr_d   = '0;
                    issue    = 1'b1;
                end
            end
            RUN: begin
                if (!step_q && elem_dual(elem_q)) begin
                    step_d = 1'b1;
                    issue  = 1'b1;
                end else begin
                    step_d = 1'b0;
                    if (addr_q != final_addr(elem_q)) begin
                        addr_d = elem_up(elem_q) ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
                        issue  = 1'b1;
                    end else if (elem_q == 3'(NUM_ELEM - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        elem_d = elem_inc;
                        addr_d = first_addr(elem_inc);
                        issue  = 1'b1;
                    end
                end
            end
            DRAIN: state_d = DONE;
        endcase
    end

    assign op_d   = elem_op(elem_d, step_d);
    assign rd_d   = op_is_rd(op_d);
    assign pat_d  = op_pat(op_d);
    assign busy_d = (state_d == RUN) || (state_d == DRAIN);
    assign fin    = (state_q == DRAIN);

    // FSM and sequencer state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            elem_q  <= '0;
            step_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            step_q  <= step_d;
            addr_q  <= addr_d;
        end
    end

    // Registered BIST port command; idle bus when no op is issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            men_q      <= 1'b0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            addr_out_q <= '0;
            din_q      <= '0;
        end else if (issue) begin
            men_q      <= 1'b1;
            wen_q      <= !rd_d;
            ren_q      <= rd_d;
            addr_out_q <= addr_d;
            din_q      <= (!rd_d && pat_d) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
        end else begin
            men_q      <= 1'b0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            addr_out_q <= '0;
            din_q      <= '0;
        end
    end

    // Expected read word and element travel with the registered command.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            exp_q      <= pat_d ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            elem_out_q <= elem_d;
        end
    end

    // Status and port-select flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
            bm_q   <= '0;
        end else begin
            busy_q <= busy_d;
            en_q   <= busy_d;
            done_q <= (state_d == DONE);
            bm_q   <= busy_d ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
        end
    end

    sram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ERR_W  (ERR_W)
    ) u_cmp (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr       (start_ok),
        .fin       (fin),
        .rd_vld    (ren_q),
        .rd_exp    (exp_q),
        .rd_addr   (addr_out_q),
        .rd_elem   (elem_out_q),
        .dout      (bus.bist_dout_i),
        .pass      (cmp_pass),
        .fail_addr (cmp_fail_addr),
        .fail_elem (cmp_fail_elem),
        .err_cnt   (cmp_err_cnt)
    );

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.pass_o      = cmp_pass;
    assign bus.fail_addr_o = cmp_fail_addr;
    assign bus.fail_elem_o = cmp_fail_elem;
    assign bus.err_cnt_o   = cmp_err_cnt;
    assign bus.bist_en_o   = en_q;
    assign bus.bist_men_o  = men_q;
    assign bus.bist_wen_o  = wen_q;
    assign bus.bist_ren_o  = ren_q;
    assign bus.bist_addr_o = addr_out_q;
    assign bus.bist_din_o  = din_q;
    assign bus.bist_bm_o   = bm_q;

endmodule
